// File: rtl/term_report_encoder_pkg.sv
// -----------------------------------------------------------------------------
// term_report_encoder_pkg
//   Shared types, ASCII constants and helpers for the terminal report encoder.
//   Contents:
//     ReportKind_t   - kind of host report requested
//     TermMode_t     - terminal mode flags queried by DECRQM
//     ASC_*          - ASCII / C1 byte constants used in VT100 replies
//     isKnownKind()  - true for the four report kinds the encoder can produce
//     modeStatus()   - DECRQM Ps value (1 set, 2 reset, 0 unrecognised)
// -----------------------------------------------------------------------------
package term_report_encoder_pkg;

    typedef enum logic [2:0] {
        RPT_DSR_STATUS  = 3'd0,
        RPT_CPR         = 3'd1,
        RPT_DECRQM_ANSI = 3'd2,
        RPT_DECRQM_DEC  = 3'd3
    } ReportKind_t;

    typedef struct packed {
        logic insertMode;        // ANSI mode 4
        logic lineFeed;          // ANSI mode 20
        logic originMode;        // DEC mode 6
        logic autoWrap;          // DEC mode 7
        logic cursorBlinking;    // DEC mode 12
        logic cursorVisibility;  // DEC mode 25
    } TermMode_t;

    localparam logic [7:0] ASC_ESC      = 8'h1B;
    localparam logic [7:0] ASC_CSI_C1   = 8'h9B;
    localparam logic [7:0] ASC_LBRACKET = 8'h5B;
    localparam logic [7:0] ASC_QMARK    = 8'h3F;
    localparam logic [7:0] ASC_SEMI     = 8'h3B;
    localparam logic [7:0] ASC_DOLLAR   = 8'h24;
    localparam logic [7:0] ASC_ZERO     = 8'h30;
    localparam logic [7:0] ASC_N        = 8'h6E;
    localparam logic [7:0] ASC_R        = 8'h52;
    localparam logic [7:0] ASC_Y        = 8'h79;

    // Width of the binary operand fed to the decimal converter.
    localparam int DEC_W = 10;

    function automatic logic isKnownKind(ReportKind_t kind);
        logic known;
        case (kind)
            RPT_DSR_STATUS, RPT_CPR, RPT_DECRQM_ANSI, RPT_DECRQM_DEC: known = 1'b1;
            default:                                                  known = 1'b0;
        endcase
        return known;
    endfunction

    function automatic logic [1:0] modeStatus(ReportKind_t kind, logic [7:0] pn, TermMode_t mode);
        logic known;
        logic flag;
        known = 1'b1;
        flag  = 1'b0;
        if (kind == RPT_DECRQM_ANSI) begin
            case (pn)
                8'd4:    flag  = mode.insertMode;
                8'd20:   flag  = mode.lineFeed;
                default: known = 1'b0;
            endcase
        end else if (kind == RPT_DECRQM_DEC) begin
            case (pn)
                8'd6:    flag  = mode.originMode;
                8'd7:    flag  = mode.autoWrap;
                8'd12:   flag  = mode.cursorBlinking;
                8'd25:   flag  = mode.cursorVisibility;
                default: known = 1'b0;
            endcase
        end else begin
            known = 1'b0;
        end
        return !known ? 2'd0 : (flag ? 2'd1 : 2'd2);
    endfunction

endpackage

// File: rtl/term_report_encoder_if.sv
// -----------------------------------------------------------------------------
// term_report_encoder_if
//   Request and reply-byte bus of the terminal report encoder.
//   Request side : req_valid/req_ready handshake with req_kind, req_param,
//                  term_mode, cursor_row, cursor_col.
//   Reply side   : tx_data/tx_valid/tx_ready byte stream toward the UART.
//   Modports     : slave  - the encoder
//                  master - the request issuer / byte consumer
// -----------------------------------------------------------------------------
interface term_report_encoder_if
    import term_report_encoder_pkg::*;
#(
    parameter int COORD_W = 8
);
    logic               req_valid;
    logic               req_ready;
    ReportKind_t        req_kind;
    logic [7:0]         req_param;
    TermMode_t          term_mode;
    logic [COORD_W-1:0] cursor_row;
    logic [COORD_W-1:0] cursor_col;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;

    modport slave (
        input  req_valid, req_kind, req_param, term_mode, cursor_row, cursor_col, tx_ready,
        output req_ready, tx_data, tx_valid
    );

    modport master (
        output req_valid, req_kind, req_param, term_mode, cursor_row, cursor_col, tx_ready,
        input  req_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/term_report_encoder_uint_to_dec.sv
// -----------------------------------------------------------------------------
// uint_to_dec
//   Combinational binary to three-digit BCD converter.
//   Ports:
//     value  in  DEC_W    binary value, expected range 0..999
//     digits out [2:0][3:0] BCD digits, [2] = hundreds, [0] = ones
//     count  out 2        number of significant digits (1..3); 0 gives 1
// -----------------------------------------------------------------------------
module uint_to_dec
    import term_report_encoder_pkg::*;
(
    input  logic [DEC_W-1:0] value,
    output logic [2:0][3:0]  digits,
    output logic [1:0]       count
);
    always_comb begin
        digits[2] = 4'(value / 10'd100);
        digits[1] = 4'((value / 10'd10) % 10'd10);
        digits[0] = 4'(value % 10'd10);
        if (digits[2] != 4'd0) begin
            count = 2'd3;
        end else if (digits[1] != 4'd0) begin
            count = 2'd2;
        end else begin
            count = 2'd1;
        end
    end
endmodule

// File: rtl/term_report_encoder.sv
// -----------------------------------------------------------------------------
// term_report_encoder
//   Host-bound VT100 reply generator. Accepts one report request per handshake
//   (DSR status, cursor position report, DECRQM ANSI/DEC mode query) and emits
//   the reply "CSI ... final" one byte per tx handshake.
//   Ports:
//     clk  in  clock
//     rst  in  asynchronous active-high reset
//     bus      term_report_encoder_if.slave (request + reply byte stream)
//   Parameters:
//     COORD_W  cursor coordinate width; coord+1 must fit three decimal digits
//   Build option:
//     TERM_REPORT_C1_EN  when defined the CSI intro is the single C1 byte 9B,
//                        otherwise it is ESC '['.
//   tx_valid/tx_data are decoded from registered state only, so they hold
//   steady during a stall and drop as soon as rst is asserted.
// -----------------------------------------------------------------------------
module term_report_encoder
    import term_report_encoder_pkg::*;
#(
    parameter int COORD_W = 8
)(
    input  logic                  clk,
    input  logic                  rst,
    term_report_encoder_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_INTRO, ST_QMARK, ST_NUM1, ST_SEMI, ST_NUM2, ST_DOLLAR, ST_FINAL
    } State_t;

    State_t           stateQ, stateD;
    logic [1:0]       digIdxQ, digIdxD;
`ifndef TERM_REPORT_C1_EN
    logic             introIdxQ, introIdxD;
`endif

    // Request snapshot
    ReportKind_t      kindQ;
    logic [7:0]       paramQ;
    TermMode_t        modeQ;
    logic [COORD_W:0] rowQ;
    logic [COORD_W:0] colQ;

    logic             accept;
    logic [DEC_W-1:0] num1, num2;
    logic [2:0][3:0]  digits1, digits2;
    logic [1:0]       count1, count2;
    logic             introDone;
    logic             txValid;
    logic [7:0]       txData;

    assign accept = bus.req_valid && (stateQ == ST_IDLE);

    // One extra bit on the coordinate so 255 reports as 256 instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kindQ  <= RPT_DSR_STATUS;
            paramQ <= '0;
            modeQ  <= '0;
            rowQ   <= '0;
            colQ   <= '0;
        end else if (accept) begin
            kindQ  <= bus.req_kind;
            paramQ <= bus.req_param;
            modeQ  <= bus.term_mode;
            rowQ   <= {1'b0, bus.cursor_row} + {{COORD_W{1'b0}}, 1'b1};
            colQ   <= {1'b0, bus.cursor_col} + {{COORD_W{1'b0}}, 1'b1};
        end
    end

    // First operand: row for CPR, Pn for DECRQM, constant 0 for DSR status.
    // Second operand: column for CPR, Ps for DECRQM.
    always_comb begin
        num1 = '0;
        num2 = '0;
        case (kindQ)
            RPT_CPR: begin
                num1 = DEC_W'(rowQ);
                num2 = DEC_W'(colQ);
            end
            RPT_DECRQM_ANSI, RPT_DECRQM_DEC: begin
                num1 = DEC_W'(paramQ);
                num2 = DEC_W'(modeStatus(kindQ, paramQ, modeQ));
            end
            default: begin
                num1 = '0;
                num2 = '0;
            end
        endcase
    end

    uint_to_dec dec1 (.value(num1), .digits(digits1), .count(count1));
    uint_to_dec dec2 (.value(num2), .digits(digits2), .count(count2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= ST_IDLE;
            digIdxQ   <= '0;
`ifndef TERM_REPORT_C1_EN
            introIdxQ <= 1'b0;
`endif
        end else begin
            stateQ    <= stateD;
            digIdxQ   <= digIdxD;
`ifndef TERM_REPORT_C1_EN
            introIdxQ <= introIdxD;
`endif
        end
    end

    // Each non-idle state presents one byte and advances on tx_ready.
    // Digit index starts at the most significant non-zero digit and counts down.
    always_comb begin
        stateD    = stateQ;
        digIdxD   = digIdxQ;
`ifndef TERM_REPORT_C1_EN
        introIdxD = introIdxQ;
`endif
        introDone = 1'b0;
        txValid   = 1'b1;
        txData    = 8'h00;
        case (stateQ)
            ST_IDLE: begin
                txValid = 1'b0;
`ifndef TERM_REPORT_C1_EN
                introIdxD = 1'b0;
`endif
                // Unknown kinds are consumed here without leaving IDLE.
                if (bus.req_valid && isKnownKind(bus.req_kind)) begin
                    stateD = ST_INTRO;
                end
            end
            ST_INTRO: begin
`ifdef TERM_REPORT_C1_EN
                txData    = ASC_CSI_C1;
                introDone = bus.tx_ready;
`else
                txData    = introIdxQ ? ASC_LBRACKET : ASC_ESC;
                introDone = bus.tx_ready && introIdxQ;
                if (bus.tx_ready && !introIdxQ) begin
                    introIdxD = 1'b1;
                end
`endif
                if (introDone) begin
                    if (kindQ == RPT_DECRQM_DEC) begin
                        stateD = ST_QMARK;
                    end else begin
                        stateD  = ST_NUM1;
                        digIdxD = count1 - 2'd1;
                    end
                end
            end
            ST_QMARK: begin
                txData = ASC_QMARK;
                if (bus.tx_ready) begin
                    stateD  = ST_NUM1;
                    digIdxD = count1 - 2'd1;
                end
            end
            ST_NUM1: begin
                txData = ASC_ZERO | {4'h0, digits1[digIdxQ]};
                if (bus.tx_ready) begin
                    if (digIdxQ == 2'd0) begin
                        stateD = (kindQ == RPT_DSR_STATUS) ? ST_FINAL : ST_SEMI;
                    end else begin
                        digIdxD = digIdxQ - 2'd1;
                    end
                end
            end
            ST_SEMI: begin
                txData = ASC_SEMI;
                if (bus.tx_ready) begin
                    stateD  = ST_NUM2;
                    digIdxD = count2 - 2'd1;
                end
            end
            ST_NUM2: begin
                txData = ASC_ZERO | {4'h0, digits2[digIdxQ]};
                if (bus.tx_ready) begin
                    if (digIdxQ == 2'd0) begin
                        stateD = (kindQ == RPT_CPR) ? ST_FINAL : ST_DOLLAR;
                    end else begin
                        digIdxD = digIdxQ - 2'd1;
                    end
                end
            end
            ST_DOLLAR: begin
                txData = ASC_DOLLAR;
                if (bus.tx_ready) begin
                    stateD = ST_FINAL;
                end
            end
            ST_FINAL: begin
                case (kindQ)
                    RPT_DSR_STATUS: txData = ASC_N;
                    RPT_CPR:        txData = ASC_R;
                    default:        txData = ASC_Y;
                endcase
                if (bus.tx_ready) begin
                    stateD = ST_IDLE;
                end
            end
            default: begin
                txValid = 1'b0;
                stateD  = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = (stateQ == ST_IDLE);
    assign bus.tx_valid  = txValid;
    assign bus.tx_data   = txData;

endmodule

// File: tb/tb_term_report_encoder.sv
// -----------------------------------------------------------------------------
// tb_term_report_encoder
//   Directed scoreboard bench for term_report_encoder. Requests push their
//   expected reply bytes into a queue; a monitor pops on every tx handshake.
//   Works for both intro variants (TERM_REPORT_C1_EN defined or not).
// -----------------------------------------------------------------------------
module tb_term_report_encoder;
    import term_report_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    term_report_encoder_if #(.COORD_W(8)) bus ();

    term_report_encoder #(.COORD_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef TERM_REPORT_C1_EN
    localparam int INTRO_N = 1;
`else
    localparam int INTRO_N = 2;
`endif

    int         checks = 0;
    int         errors = 0;
    int         popped = 0;
    logic [7:0] expQ[$];
    bit         randomReady = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic pushReply(logic [63:0] body, int n);
`ifdef TERM_REPORT_C1_EN
        expQ.push_back(8'h9B);
`else
        expQ.push_back(8'h1B);
        expQ.push_back(8'h5B);
`endif
        for (int i = 0; i < n; i++) begin
            expQ.push_back(body[8*(n-1-i) +: 8]);
        end
    endtask

    function automatic TermMode_t mkMode(bit ins, bit lf, bit org, bit aw, bit blk, bit vis);
        TermMode_t m;
        m.insertMode       = ins;
        m.lineFeed         = lf;
        m.originMode       = org;
        m.autoWrap         = aw;
        m.cursorBlinking   = blk;
        m.cursorVisibility = vis;
        return m;
    endfunction

    // Returns #1 after the accepting clock edge; inputs are scrambled afterwards
    // so a reply that failed to snapshot would show up as wrong bytes.
    task automatic issue(ReportKind_t kind, logic [7:0] pn, TermMode_t mode,
                         logic [7:0] row, logic [7:0] col,
                         logic [63:0] body, int n, bit expectReply);
        int guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            check("reqReadyTimeout", 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_kind   = kind;
        bus.req_param  = pn;
        bus.term_mode  = mode;
        bus.cursor_row = row;
        bus.cursor_col = col;
        bus.req_valid  = 1'b1;
        if (expectReply) pushReply(body, n);
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_param  = ~pn;
        bus.term_mode  = ~mode;
        bus.cursor_row = ~row;
        bus.cursor_col = ~col;
    endtask

    task automatic waitDrain(bit toggle);
        int g = 0;
        while ((expQ.size() != 0 || !bus.req_ready) && g < 500) begin
            @(posedge clk);
            #1;
            if (toggle) bus.term_mode = ~bus.term_mode;
            g++;
        end
        check("drainTimeout", 32'(g < 500), 32'd1);
    endtask

    // Monitor: drives tx_ready at each falling edge, then inspects the values
    // that the next rising edge will see.
    initial begin
        logic       holdPending;
        logic [7:0] heldData;
        logic [7:0] exp;
        holdPending  = 1'b0;
        heldData     = 8'h00;
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.tx_ready = randomReady ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (!bus.tx_valid) begin
                holdPending = 1'b0;
            end else begin
                if (holdPending) check("stallHold", 32'(bus.tx_data), 32'(heldData));
                holdPending = 1'b0;
                if (bus.tx_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpectedByte: got %0h, required no byte", bus.tx_data);
                    end else begin
                        exp = expQ.pop_front();
                        check("txByte", 32'(bus.tx_data), 32'(exp));
                    end
                    popped++;
                end else begin
                    holdPending = 1'b1;
                    heldData    = bus.tx_data;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int p0;
        int lowCycles;
        int sawValid;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_kind   = RPT_DSR_STATUS;
        bus.req_param  = 8'd0;
        bus.term_mode  = '0;
        bus.cursor_row = 8'd0;
        bus.cursor_col = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rstReqReady", 32'(bus.req_ready), 32'd1);
        check("rstTxValid",  32'(bus.tx_valid),  32'd0);
        check("rstTxData",   32'(bus.tx_data),   32'd0);
        rst = 1'b0;

        // DECRQM DEC 25 visible: latency and gap-free streaming
        p0 = popped;
        issue(RPT_DECRQM_DEC, 8'd25, mkMode(0,0,0,0,0,1), 8'd0, 8'd0, 64'h3F32353B312479, 7, 1'b1);
        check("txValidAfterAccept", 32'(bus.tx_valid), 32'd1);
        lowCycles = 0;
        while (!bus.req_ready && lowCycles < 50) begin
            @(posedge clk);
            #1;
            lowCycles++;
        end
        check("reqReadyLowCycles", 32'(lowCycles), 32'(7 + INTRO_N));
        check("byteCountNoBubble", 32'(popped - p0), 32'(7 + INTRO_N));

        // Back-to-back requests
        issue(RPT_DECRQM_ANSI, 8'd4, mkMode(0,1,1,1,1,1), 8'd0, 8'd0, 64'h343B322479, 5, 1'b1);
        issue(RPT_CPR, 8'd0, '0, 8'd0, 8'd79, 64'h313B383052, 5, 1'b1);
        issue(RPT_CPR, 8'd0, '0, 8'd255, 8'd0, 64'h3235363B3152, 6, 1'b1);
        issue(RPT_DECRQM_ANSI, 8'd20, mkMode(0,1,0,0,0,0), 8'd0, 8'd0, 64'h32303B312479, 6, 1'b1);
        issue(RPT_DECRQM_DEC, 8'd12, mkMode(0,0,0,0,1,0), 8'd0, 8'd0, 64'h3F31323B312479, 7, 1'b1);
        issue(RPT_DECRQM_DEC, 8'd7, mkMode(1,1,1,0,1,1), 8'd0, 8'd0, 64'h3F373B322479, 6, 1'b1);
        issue(RPT_DECRQM_ANSI, 8'd0, mkMode(1,1,1,1,1,1), 8'd0, 8'd0, 64'h303B302479, 5, 1'b1);
        waitDrain(1'b0);

        // Random back-pressure with term_mode toggling mid-reply
        randomReady = 1'b1;
        issue(RPT_DECRQM_DEC, 8'd99, mkMode(1,1,1,1,1,1), 8'd0, 8'd0, 64'h3F39393B302479, 7, 1'b1);
        waitDrain(1'b1);
        issue(RPT_DECRQM_DEC, 8'd6, mkMode(0,0,1,0,0,0), 8'd0, 8'd0, 64'h3F363B312479, 6, 1'b1);
        waitDrain(1'b1);
        randomReady = 1'b0;
        repeat (2) @(posedge clk);

        // Reset after the third byte of a CPR
        p0 = popped;
        issue(RPT_CPR, 8'd0, '0, 8'd9, 8'd19, 64'h31303B323052, 6, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("bytesBeforeReset", 32'(popped - p0), 32'd3);
        rst = 1'b1;
        #1;
        check("resetTxValid",  32'(bus.tx_valid),  32'd0);
        check("resetReqReady", 32'(bus.req_ready), 32'd1);
        check("resetTxData",   32'(bus.tx_data),   32'd0);
        check("abandonedBytes", 32'(expQ.size()), 32'(6 + INTRO_N - 3));
        expQ.delete();
        #1;
        rst = 1'b0;
        issue(RPT_DSR_STATUS, 8'd0, '0, 8'd0, 8'd0, 64'h306E, 2, 1'b1);
        waitDrain(1'b0);

        // Unknown kind is consumed silently
        issue(ReportKind_t'(3'd6), 8'd25, '1, 8'd1, 8'd1, 64'h0, 0, 1'b0);
        check("unknownReqReady", 32'(bus.req_ready), 32'd1);
        sawValid = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.tx_valid) sawValid++;
            @(posedge clk);
            #1;
        end
        check("unknownNoTxValid", 32'(sawValid), 32'd0);
        issue(RPT_DSR_STATUS, 8'd0, '0, 8'd0, 8'd0, 64'h306E, 2, 1'b1);
        waitDrain(1'b0);
        repeat (3) @(posedge clk);
        check("queueEmptyAtEnd", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
